// File: rtl/btb_fetch_pc.sv
// -----------------------------------------------------------------------------
// btb_fetch_pc
//   Fetch-stage next-PC unit. Holds the architectural fetch PC and a
//   direct-mapped branch target buffer. The BTB lookup on pc_out is
//   combinational. The lookup result is combined with the gshare direction bit
//   (gpre) to pick the next fetch address. EX-stage redirects and BTB updates
//   are accepted on the clock edge.
//
// Parameters
//   BTB_ENTRIES  number of BTB entries (power of two)
//   IDX_W        log2(BTB_ENTRIES)
//   RESET_PC     fetch PC after reset
//
// Ports
//   clk          clock; all state updates on posedge
//   rst          synchronous, active-high reset
//   stall        hold pc_out
//   gpre         gshare direction for pc_out (1 = taken)
//   redirect     restart fetch at redirect_pc (overrides stall)
//   redirect_pc  corrected fetch address
//   upd_en       write BTB entry for a resolved taken branch/jump
//   upd_pc       PC of the resolved branch
//   upd_target   its taken target (bits [1:0] ignored)
//   pc_out       current fetch PC (registered)
//   btb_hit      valid entry whose tag matches pc_out
//   pred_taken   btb_hit & gpre
//   pred_target  stored target with low bits zero; 0 on a miss
// -----------------------------------------------------------------------------
module btb_fetch_pc #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        gpre,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    output logic [31:0] pc_out,
    output logic        btb_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
    logic [29:0]            tgt_mem [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [31:0]      next_pc;

    assign rd_idx = pc_out[IDX_W+1:2];
    assign rd_tag = pc_out[31:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[31:IDX_W+2];

    // Lookup reads only the stored arrays. A write in the same cycle lands at
    // the edge, so a colliding read still sees the old entry.
    always_comb begin
        btb_hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        pred_taken  = btb_hit & gpre;
        pred_target = btb_hit ? {tgt_mem[rd_idx], 2'b00} : '0;
    end

    always_comb begin
        next_pc = pc_out + 32'd4;
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc_out;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= RESET_PC;
        end else begin
            pc_out <= next_pc;
        end
    end

    // Valid bits are the only BTB state that needs reset; tag/target contents
    // are never observed while the matching valid bit is clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (upd_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && upd_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= upd_target[31:2];
        end
    end

endmodule
